// File: rtl/ifu_axi_ar_slice.sv
// ifu_axi_ar_slice
// Registered skid slice on the IFU AXI read-address channel. A main register
// drives the fabric side and a skid register absorbs the one extra request
// that can arrive while the fabric stalls. ifu_axi_arready comes from flops
// and rst only. The slice also limits how many reads can be in flight at once.
module ifu_axi_ar_slice #(
   parameter int ADDR_W          = 32,
   parameter int ID_W            = 3,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_axi_arvalid,
   output logic              ifu_axi_arready,
   input  logic [ADDR_W-1:0] ifu_axi_araddr,
   input  logic [ID_W-1:0]   ifu_axi_arid,
   output logic              m_arvalid,
   input  logic              m_arready,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [ID_W-1:0]   m_arid,
   input  logic              r_done,
   output logic [3:0]        outstanding,
   output logic              protocol_err
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] main_addr;
   logic [ID_W-1:0]   main_id;
   logic [ADDR_W-1:0] skid_addr;
   logic [ID_W-1:0]   skid_id;
   logic              accept;
   logic              issue;
   logic              retire;

   assign accept = ifu_axi_arvalid & ifu_axi_arready;
   assign issue  = m_arvalid & m_arready;
   // A completion with nothing in flight is an error and must not wrap the count.
   assign retire = r_done & (outstanding != 4'd0);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Next-state logic for the two-entry buffer.
   // NOTE: state_nxt gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (accept) state_nxt = ONE;
         ONE: begin
            if (accept && !issue)      state_nxt = FULL;
            else if (!accept && issue) state_nxt = EMPTY;
         end
         FULL: if (issue) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   // Outputs: valid follows occupancy, ready depends only on flops and rst.
   always_comb begin
      m_arvalid       = (state != EMPTY);
      ifu_axi_arready = !rst && (state != FULL) && (outstanding < MAX_CNT);
   end

   // Main register: loads the input when it is empty or draining, or the skid
   // entry when the buffer was full.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_addr <= '0;
         main_id   <= '0;
      end else if (((state == EMPTY) && accept) || ((state == ONE) && accept && issue)) begin
         main_addr <= ifu_axi_araddr;
         main_id   <= ifu_axi_arid;
      end else if ((state == FULL) && issue) begin
         main_addr <= skid_addr;
         main_id   <= skid_id;
      end
   end

   // Skid register: captures the request that arrives while the main entry stalls.
   // NOTE: the skid entry is not reset; it is only read in FULL, which is
   // always reached by writing it first.
   always_ff @(posedge clk) begin
      if ((state == ONE) && accept && !issue) begin
         skid_addr <= ifu_axi_araddr;
         skid_id   <= ifu_axi_arid;
      end
   end

   assign m_araddr = main_addr;
   assign m_arid   = main_id;

   // In-flight counter and sticky protocol error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding  <= 4'd0;
         protocol_err <= 1'b0;
      end else begin
         outstanding <= outstanding + {3'b000, accept} - {3'b000, retire};
         if (r_done && (outstanding == 4'd0)) protocol_err <= 1'b1;
      end
   end

endmodule
